// File: rtl/hadd_exerciser.sv
// Stimulus generator and checker for an external half-adder board: steps {a,b} through
// 00..11, samples the returned sum/carry, and reports on LEDs. Option: HADD_EX_FIRST_FAIL_EN.
module hadd_exerciser #(
  parameter int unsigned PRESCALE_W    = 16,
  parameter int unsigned TICK_COUNT    = 91,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       in_sum,
  input  logic       in_carry,
  output logic       out_a,
  output logic       out_b,
  output logic [1:0] step_led,
  output logic       pass_led,
  output logic       fail_led,
  output logic [7:0] err_count
`ifdef HADD_EX_FIRST_FAIL_EN
  ,
  output logic [3:0] first_fail
`endif
);

  localparam int unsigned Stage2W = (TICK_COUNT < 1) ? 1 : $clog2(TICK_COUNT + 1);
  localparam logic [Stage2W-1:0] TickLast   = Stage2W'(TICK_COUNT);
  localparam logic [7:0]         SettleLast = 8'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {StDrive, StSettle, StSample, StHold} state_e;

  // Input synchronisers: always running so the board lines stay tracked while frozen.
  logic sum_s1_q, sum_s2_q, carry_s1_q, carry_s2_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sum_s1_q   <= 1'b0;
      sum_s2_q   <= 1'b0;
      carry_s1_q <= 1'b0;
      carry_s2_q <= 1'b0;
    end else begin
      sum_s1_q   <= in_sum;
      sum_s2_q   <= sum_s1_q;
      carry_s1_q <= in_carry;
      carry_s2_q <= carry_s1_q;
    end
  end

  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic [Stage2W-1:0]    stage2_q, stage2_d;
  logic                  tick_q, tick_d;
  state_e                state_q, state_d;
  logic [7:0]            settle_q, settle_d;
  logic [1:0]            vec_q, vec_d;
  logic                  a_q, a_d, b_q, b_d;
  logic                  sweep_ok_q, sweep_ok_d;
  logic                  pass_q, pass_d;
  logic                  fail_q, fail_d;
  logic [7:0]            err_q, err_d;
  logic                  mismatch;
`ifdef HADD_EX_FIRST_FAIL_EN
  logic [3:0]            first_fail_q, first_fail_d;
`endif

  assign mismatch = (sum_s2_q != (a_q ^ b_q)) || (carry_s2_q != (a_q & b_q));

  always_comb begin
    presc_d    = presc_q;
    stage2_d   = stage2_q;
    tick_d     = tick_q;
    state_d    = state_q;
    settle_d   = settle_q;
    vec_d      = vec_q;
    a_d        = a_q;
    b_d        = b_q;
    sweep_ok_d = sweep_ok_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    err_d      = err_q;
`ifdef HADD_EX_FIRST_FAIL_EN
    first_fail_d = first_fail_q;
`endif

    // With run low everything above simply holds, including a pending tick.
    if (run) begin
      presc_d = presc_q + PRESCALE_W'(1);
      tick_d  = 1'b0;
      if (&presc_q) begin
        if (stage2_q == TickLast) begin
          stage2_d = '0;
          tick_d   = 1'b1;
        end else begin
          stage2_d = stage2_q + Stage2W'(1);
        end
      end

      unique case (state_q)
        StDrive: begin
          a_d      = vec_q[1];
          b_d      = vec_q[0];
          settle_d = 8'd0;
          if (vec_q == 2'd0) sweep_ok_d = 1'b1;
          state_d  = StSettle;
        end
        StSettle: begin
          settle_d = settle_q + 8'd1;
          if (settle_q == SettleLast) state_d = StSample;
        end
        StSample: begin
          if (mismatch) begin
            fail_d     = 1'b1;
            pass_d     = 1'b0;
            sweep_ok_d = 1'b0;
            if (err_q != 8'hff) err_d = err_q + 8'd1;
`ifdef HADD_EX_FIRST_FAIL_EN
            if (!fail_q) first_fail_d = {a_q, b_q, sum_s2_q, carry_s2_q};
`endif
          end else if (vec_q == 2'd3 && sweep_ok_q && !fail_q) begin
            pass_d = 1'b1;
          end
          state_d = StHold;
        end
        StHold: begin
          // Ticks outside HOLD are lost; that vector just lasts an extra period.
          if (tick_q) begin
            vec_d   = vec_q + 2'd1;
            state_d = StDrive;
          end
        end
        default: state_d = StDrive;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      presc_q    <= '0;
      stage2_q   <= '0;
      tick_q     <= 1'b0;
      state_q    <= StDrive;
      settle_q   <= 8'd0;
      vec_q      <= 2'd0;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      sweep_ok_q <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      err_q      <= 8'd0;
`ifdef HADD_EX_FIRST_FAIL_EN
      first_fail_q <= 4'd0;
`endif
    end else begin
      presc_q    <= presc_d;
      stage2_q   <= stage2_d;
      tick_q     <= tick_d;
      state_q    <= state_d;
      settle_q   <= settle_d;
      vec_q      <= vec_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sweep_ok_q <= sweep_ok_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      err_q      <= err_d;
`ifdef HADD_EX_FIRST_FAIL_EN
      first_fail_q <= first_fail_d;
`endif
    end
  end

  assign out_a     = a_q;
  assign out_b     = b_q;
  assign step_led  = {a_q, b_q};
  assign pass_led  = pass_q;
  assign fail_led  = fail_q;
  assign err_count = err_q;
`ifdef HADD_EX_FIRST_FAIL_EN
  assign first_fail = first_fail_q;
`endif

endmodule

// File: doc/hadd_exerciser.md
Name: hadd_exerciser

Overview:
Stimulus and checker for the external half-adder board. It drives the A/B PMOD lines through all four input vectors at a half-second step rate. It reads back the sum and carry lines, compares them with a^b and a&b, and reports the result on LEDs. It sits on the tester board and connects pin-to-pin with the half-adder board's PMOD1/PMOD2 inputs and its LED1/LED2 outputs.

Parameters:
PRESCALE_W, 16, width of first-stage free-running prescaler
TICK_COUNT, 91, second-stage terminal count; step period = 2^PRESCALE_W*(TICK_COUNT+1) clk cycles (≈0.502 s at 12 MHz)
SETTLE_CYCLES, 4, clk cycles to wait after driving a vector before sampling; range 1..255; must be < step period - 3

Ports:
clk  in  1  system clock (12 MHz)
reset  in  1  synchronous, active-low reset
run  in  1  1 = exercise, 0 = freeze all sequential state except input synchronisers
in_sum  in  1  DUT sum line, asynchronous
in_carry  in  1  DUT carry line, asynchronous
out_a  out  1  drive to DUT input A
out_b  out  1  drive to DUT input B
step_led  out  2  current vector index {a,b}
pass_led  out  1  at least one full clean sweep completed, no failure since reset
fail_led  out  1  sticky mismatch flag
err_count  out  8  saturating mismatch count

Behaviour:
- Reset (reset==0 at posedge clk) dominates all other inputs. Reset values: out_a=0, out_b=0, step_led=0, pass_led=0, fail_led=0, err_count=0, prescaler=0, stage2=0, settle counter=0, state=DRIVE.
- in_sum and in_carry pass through a 2-flop synchroniser. The synchroniser runs every cycle regardless of run. It is cleared to 0 by reset.
- Tick generator advances only when run==1.
  - The prescaler increments each cycle.
  - When the prescaler==all-ones: if stage2==TICK_COUNT, then stage2<=0 and tick<=1 for one cycle; otherwise stage2 increments.
- FSM states: DRIVE, SETTLE, SAMPLE, HOLD. All transitions require run==1; with run==0 the state and all counters hold.
  - DRIVE: out_a/out_b <= vector bits; settle counter <= 0; go to SETTLE.
  - SETTLE: the settle counter increments; when it reaches SETTLE_CYCLES-1, go to SAMPLE.
  - SAMPLE: compare the synchronised sum/carry with expected a^b, a&b. On mismatch: fail_led<=1, err_count<=err_count+1 saturating at 255, sweep_ok<=0. Then go to HOLD.
  - HOLD: on tick, vector <= vector+1 (wraps 3->0) and go to DRIVE. A tick arriving in any other state is dropped; the vector then holds for an extra period.
- Sweep tracking:
  - sweep_ok is set to 1 on entering DRIVE for vector 0.
  - In the SAMPLE of vector 3: if sweep_ok==1 and fail_led==0, then pass_led<=1.
  - Any mismatch clears pass_led in the same cycle fail_led sets. pass_led then stays 0 until reset.
- Latency: out_a/out_b change 1 cycle after the HOLD tick. The sample is taken SETTLE_CYCLES+1 cycles after the drive update. The synchroniser adds 2 cycles, so the DUT must settle within SETTLE_CYCLES-2 cycles of the combinational/registered response.
- step_led mirrors the registered vector, which updates in the same cycle as out_a/out_b.
- Reset mid-operation: the next cycle shows all reset values. There is no partial sweep credit.

Optional Feature:
Macro HADD_EX_FIRST_FAIL_EN.
- Defined: adds output first_fail (4 bits) = {a,b,sum,carry} captured at the first mismatch after reset. Later mismatches do not overwrite it. Reset value is 0.
- Undefined: no port and no capture register; behaviour is otherwise identical.

Test Plan:
1. PRESCALE_W=2, TICK_COUNT=1 (period 8), SETTLE_CYCLES=3, correct DUT model with 1-cycle registered output, run=1 -> out_a/out_b step 00,01,10,11 every 8 cycles; pass_led=1 after the vector-3 sample; err_count=0; fail_led=0.
2. Same params, DUT carry stuck at 1 -> mismatches on vectors 00, 01, 10; fail_led=1 at the first sample; err_count=3 after one sweep, 6 after two; pass_led=0 throughout.
3. Sum stuck at 0 for 90 sweeps (180 mismatches), then continue -> err_count saturates at 255 and stays at 255.
4. run=0 for 20 cycles during SETTLE of vector 01 -> out_a/out_b, state, prescaler, stage2 and err_count unchanged; after run=1 the sample occurs after the remaining settle cycles; results match test 1.
5. fail_led=1, err_count=5, reset driven low for 1 cycle during HOLD -> next posedge: all outputs at reset values; a clean sweep afterwards gives pass_led=1.
6. HADD_EX_FIRST_FAIL_EN defined, DUT inverts sum on vector 10 only, later forced carry error on vector 11 -> first_fail=4'b1000, unchanged after the vector-11 failure.
